// File: rtl/formatter.sv
// rtl/formatter.sv - MCDF formatter: selects a channel, buffers one packet, streams it out framed.
module formatter (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        f2a_id_req_o,
    input  logic        a2f_val_i,
    input  logic [1:0]  a2f_id_i,
    input  logic [31:0] a2f_data_i,
    input  logic [2:0]  a2f_pkglen_sel_i,
    output logic        f2a_ack_o,
    output logic        fmt_req_o,
    input  logic        fmt_grant_i,
    output logic [1:0]  fmt_chid_o,
    output logic [5:0]  fmt_length_o,
    output logic        fmt_start_o,
    output logic        fmt_end_o,
    output logic [31:0] fmt_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WAIT,
        S_COLLECT,
        S_REQ,
        S_SEND
    } state_t;

    state_t      state;
    logic [1:0]  chid_r;
    logic [5:0]  len_r;
    logic [5:0]  wcnt;
    logic [5:0]  rcnt;
    logic [5:0]  wcnt_next;
    logic [5:0]  rcnt_next;
    logic [31:0] pkt_buf [32];

    function automatic logic [5:0] decode_len(input logic [2:0] sel);
        case (sel)
            3'd0:    decode_len = 6'd4;
            3'd1:    decode_len = 6'd8;
            3'd2:    decode_len = 6'd16;
            default: decode_len = 6'd32;
        endcase
    endfunction

    assign wcnt_next = wcnt + 6'd1;
    assign rcnt_next = rcnt + 6'd1;

    // The wcnt guard keeps a full buffer from accepting one word too many.
    assign f2a_ack_o = (state == S_COLLECT) && a2f_val_i && (wcnt != len_r);

    // Buffer storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (f2a_ack_o) begin
            pkt_buf[wcnt[4:0]] <= a2f_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            chid_r       <= 2'd0;
            len_r        <= 6'd0;
            wcnt         <= 6'd0;
            rcnt         <= 6'd0;
            f2a_id_req_o <= 1'b0;
            fmt_req_o    <= 1'b0;
            fmt_chid_o   <= 2'd0;
            fmt_length_o <= 6'd0;
            fmt_start_o  <= 1'b0;
            fmt_end_o    <= 1'b0;
            fmt_data_o   <= 32'd0;
        end else begin
            f2a_id_req_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    state        <= S_SEL;
                    f2a_id_req_o <= 1'b1;
                end
                S_SEL: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (a2f_id_i == 2'b11) begin
                        state <= S_IDLE;
                    end else begin
                        chid_r <= a2f_id_i;
                        len_r  <= decode_len(a2f_pkglen_sel_i);
                        wcnt   <= 6'd0;
                        state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (f2a_ack_o) begin
                        wcnt <= wcnt_next;
                        if (wcnt_next == len_r) begin
                            state        <= S_REQ;
                            fmt_req_o    <= 1'b1;
                            fmt_chid_o   <= chid_r;
                            fmt_length_o <= len_r;
                        end
                    end
                end
                S_REQ: begin
                    // First word is registered on the grant edge so it appears one cycle later.
                    if (fmt_grant_i) begin
                        state       <= S_SEND;
                        fmt_req_o   <= 1'b0;
                        rcnt        <= 6'd0;
                        fmt_data_o  <= pkt_buf[0];
                        fmt_start_o <= 1'b1;
                        fmt_end_o   <= (len_r == 6'd1);
                    end
                end
                S_SEND: begin
                    if (rcnt == len_r - 6'd1) begin
                        state        <= S_IDLE;
                        fmt_data_o   <= 32'd0;
                        fmt_start_o  <= 1'b0;
                        fmt_end_o    <= 1'b0;
                        fmt_chid_o   <= 2'd0;
                        fmt_length_o <= 6'd0;
                    end else begin
                        rcnt        <= rcnt_next;
                        fmt_data_o  <= pkt_buf[rcnt_next[4:0]];
                        fmt_start_o <= 1'b0;
                        fmt_end_o   <= (rcnt_next == len_r - 6'd1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_formatter.sv
// tb/tb_formatter.sv - scoreboard bench for formatter with directed packets.
module tb_formatter;

    logic        clk;
    logic        rstn;
    logic        f2a_id_req_o;
    logic        a2f_val;
    logic [1:0]  a2f_id;
    logic [31:0] a2f_data;
    logic [2:0]  a2f_pkglen_sel;
    logic        f2a_ack_o;
    logic        fmt_req_o;
    logic        fmt_grant;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic        fmt_start_o;
    logic        fmt_end_o;
    logic [31:0] fmt_data_o;

    typedef struct packed {
        logic [1:0]  chid;
        logic [5:0]  len;
        logic [31:0] data;
        logic        s;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_pkt = 0;

    formatter dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .f2a_id_req_o     (f2a_id_req_o),
        .a2f_val_i        (a2f_val),
        .a2f_id_i         (a2f_id),
        .a2f_data_i       (a2f_data),
        .a2f_pkglen_sel_i (a2f_pkglen_sel),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_req_o        (fmt_req_o),
        .fmt_grant_i      (fmt_grant),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o),
        .fmt_data_o       (fmt_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {54'd0, f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_start_o, fmt_end_o, fmt_chid_o, |fmt_length_o, |fmt_data_o};
    endfunction

    // Output monitor: pops an expected word for each cycle of a framed packet.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            in_pkt = 0;
        end else if (fmt_start_o || in_pkt) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", {fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o}, 64'h0);
                if (fmt_start_o == 1'b0 && fmt_end_o == 1'b0 && fmt_data_o == 32'd0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected empty queue while framing");
                end
            end else begin
                e = exp_q.pop_front();
                chk("out_word", {fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o}, e);
            end
            in_pkt = !fmt_end_o;
        end else begin
            chk("idle_out", {fmt_data_o, fmt_end_o}, 64'h0);
        end
    end

    task automatic do_packet(input logic [1:0] id, input logic [2:0] sel, input logic [31:0] base,
                             input logic [31:0] step, input bit alt, input int gdelay,
                             input int len, input int reset_at, output int acks);
        int   t;
        int   c;
        int   idx;
        int   reqc;
        int   k;
        bit   v;
        bit   done;
        exp_t e;
        acks = 0;
        for (int i = 0; i < len; i++) begin
            e.chid = id;
            e.len  = 6'(len);
            e.data = base + 32'(i) * step;
            e.s    = (i == 0);
            e.e    = (i == len - 1);
            exp_q.push_back(e);
        end
        fmt_grant = (gdelay == 0);
        t = 0;
        while (!f2a_id_req_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("id_req_seen", {63'd0, f2a_id_req_o}, 64'd1);
        a2f_id = id;
        a2f_pkglen_sel = sel;
        @(negedge clk);
        a2f_val = 1'b1;
        a2f_data = base;
        #1;
        chk("ack_in_wait", {63'd0, f2a_ack_o}, 64'd0);
        c = 0;
        idx = 0;
        while (idx < len && c < 300) begin
            @(negedge clk);
            if (c == 0) begin
                a2f_id = 2'b11;
                a2f_pkglen_sel = 3'd0;
            end
            v = alt ? (c % 2 == 0) : 1'b1;
            a2f_val = v;
            a2f_data = base + 32'(idx) * step;
            #1;
            chk("ack_eq_val", {63'd0, f2a_ack_o}, {63'd0, v});
            if (f2a_ack_o) begin
                idx++;
                acks++;
            end
            c++;
        end
        @(negedge clk);
        a2f_val = 1'b0;
        a2f_data = 32'd0;
        t = 0;
        while (!fmt_req_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_seen", {63'd0, fmt_req_o}, 64'd1);
        if (!fmt_req_o) return;
        reqc = 0;
        while (fmt_req_o && reqc < 100) begin
            reqc++;
            chk("req_hold", {54'd0, fmt_chid_o, fmt_length_o, f2a_ack_o, f2a_id_req_o},
                {54'd0, id, 6'(len), 1'b0, 1'b0});
            if (gdelay > 0 && reqc == gdelay) fmt_grant = 1'b1;
            @(negedge clk);
        end
        fmt_grant = 1'b0;
        chk("req_cycles", 64'(reqc), 64'(gdelay == 0 ? 1 : gdelay));
        k = 0;
        done = 0;
        while (!done && k < 40) begin
            if (k == 0) chk("first_at_g1", {63'd0, fmt_start_o}, 64'd1);
            if (k == reset_at) begin
                #1 rstn = 1'b0;
                @(negedge clk);
                chk("mid_reset_outs", all_outs(), 64'd0);
                #1;
                exp_q.delete();
                rstn = 1'b1;
                chk("idreq_at_r", {63'd0, f2a_id_req_o}, 64'd0);
                @(negedge clk);
                chk("idreq_at_r1", {63'd0, f2a_id_req_o}, 64'd1);
                return;
            end
            if (fmt_end_o) done = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("end_index", 64'(k), 64'(len - 1));
        @(negedge clk);
        chk("after_end_outs", all_outs(), 64'd0);
    endtask

    initial begin
        int acks;
        rstn = 1'b0;
        a2f_val = 1'b0;
        a2f_id = 2'b11;
        a2f_data = 32'd0;
        a2f_pkglen_sel = 3'd0;
        fmt_grant = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);
        #1 rstn = 1'b1;
        // Cycle R is this one; arbiter reports no channel, so pulses repeat every 3 cycles.
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            chk("retry_id_req", {63'd0, f2a_id_req_o}, {63'd0, (n == 1 || n == 4 || n == 7)});
            chk("retry_no_ack_req", {62'd0, f2a_ack_o, fmt_req_o}, 64'd0);
        end

        do_packet(2'd0, 3'd0, 32'h11, 32'h11, 1'b0, 0, 4, -1, acks);
        chk("acks_len4", 64'(acks), 64'd4);
        do_packet(2'd1, 3'd1, 32'h100, 32'h1, 1'b1, 0, 8, -1, acks);
        chk("acks_alt8", 64'(acks), 64'd8);
        do_packet(2'd2, 3'd0, 32'h55, 32'h3, 1'b0, 10, 4, -1, acks);
        chk("acks_grant_wait", 64'(acks), 64'd4);
        do_packet(2'd2, 3'd6, 32'hA000_0000, 32'h1, 1'b0, 0, 32, -1, acks);
        chk("acks_len32", 64'(acks), 64'd32);
        do_packet(2'd0, 3'd1, 32'h200, 32'h1, 1'b0, 0, 8, 5, acks);
        do_packet(2'd1, 3'd2, 32'h300, 32'h10, 1'b0, 3, 16, -1, acks);
        chk("acks_after_reset", 64'(acks), 64'd16);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
